// File: rtl/reg_bank_dump_if.sv
// Register-dump stream bundle: word, address, last flag and valid/ready.
// master drives the word stream; slave is the sink that drives ready.
interface reg_bank_dump_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_addr;
  logic              dump_valid;
  logic              dump_ready;
  logic              dump_last;

  modport master (
    output dump_data,
    output dump_addr,
    output dump_valid,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_data,
    input  dump_addr,
    input  dump_valid,
    input  dump_last,
    output dump_ready
  );

endinterface

// File: rtl/reg_bank_dump.sv
// Register bank read-out engine: walks first_addr..last_addr on one bank read
// port and streams each word with its address over the dump interface.
// Ports: clk_CPU, rst (sync, active high), start/first_addr/last_addr request,
// rd_addr/rd_data bank port, busy/done/err status, dump (stream master).
module reg_bank_dump #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk_CPU,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  reg_bank_dump_if.master   dump
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND,
    DONE
  } state_t;

  // One extra bit so NUM_REGS == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_last_q, dump_last_d;
  logic              err_q, err_d;
  logic              req_legal;
  logic              xfer;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    end_d       = end_q;
    rd_addr_d   = rd_addr_q;
    dump_addr_d = dump_addr_q;
    dump_data_d = dump_data_q;
    dump_last_d = dump_last_q;
    err_d       = 1'b0;
    req_legal   = (first_addr <= last_addr) &&
                  ({1'b0, last_addr} < LIMIT);
    xfer        = (state_q == SEND) && dump.dump_ready;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (req_legal) begin
            ptr_d   = first_addr;
            end_d   = last_addr;
            state_d = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        rd_addr_d   = ptr_q;
        dump_data_d = rd_data;
        dump_addr_d = ptr_q;
        dump_last_d = (ptr_q == end_q);
        state_d     = SEND;
      end
      SEND: begin
        if (xfer) begin
          if (dump_last_q) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_CPU) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      end_q       <= '0;
      rd_addr_q   <= '0;
      dump_addr_q <= '0;
      dump_data_q <= '0;
      dump_last_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      end_q       <= end_d;
      rd_addr_q   <= rd_addr_d;
      dump_addr_q <= dump_addr_d;
      dump_data_q <= dump_data_d;
      dump_last_q <= dump_last_d;
      err_q       <= err_d;
    end
  end

  // Bank read is asynchronous, so the address must be ptr during LOAD
  // itself; elsewhere it holds the last address read.
  assign rd_addr = (state_q == LOAD) ? ptr_q : rd_addr_q;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

  assign dump.dump_valid = (state_q == SEND);
  assign dump.dump_data  = dump_data_q;
  assign dump.dump_addr  = dump_addr_q;
  assign dump.dump_last  = dump_last_q;

endmodule

// File: tb/tb_reg_bank_dump.sv
// Directed bench for reg_bank_dump: full dumps, backpressure, single word,
// illegal requests, mid-dump reset and start-while-busy.
module tb_reg_bank_dump;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk_CPU = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] bank [0:NR-1];

  logic          start2;
  logic [5:0]    first2;
  logic [5:0]    last2;
  logic [5:0]    rd_addr2;
  logic [DW-1:0] rd_data2;
  logic          busy2;
  logic          done2;
  logic          err2;

  always #5 clk_CPU = ~clk_CPU;

  reg_bank_dump_if #(.DATA_W(DW), .ADDR_W(AW)) dif ();
  reg_bank_dump_if #(.DATA_W(DW), .ADDR_W(6)) dif2 ();

  assign rd_data  = bank[rd_addr];
  assign rd_data2 = 32'h0000_0000;

  reg_bank_dump #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)
  ) dut (
    .clk_CPU   (clk_CPU),
    .rst       (rst),
    .start     (start),
    .first_addr(first_addr),
    .last_addr (last_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dump      (dif)
  );

  reg_bank_dump #(
    .DATA_W(DW), .ADDR_W(6), .NUM_REGS(32)
  ) dut2 (
    .clk_CPU   (clk_CPU),
    .rst       (rst),
    .start     (start2),
    .first_addr(first2),
    .last_addr (last2),
    .rd_addr   (rd_addr2),
    .rd_data   (rd_data2),
    .busy      (busy2),
    .done      (done2),
    .err       (err2),
    .dump      (dif2)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  int    vectors = 0;
  int    miscompares = 0;
  word_t wq[$];
  int    n_done;
  int    done_cyc;
  int    last_xfer_cyc;
  int    first_valid_cyc;
  int    hold_errs;
  int    n_err;

  task automatic step();
    @(posedge clk_CPU);
    #1;
  endtask

  task automatic start_dump(input logic [AW-1:0] f,
                            input logic [AW-1:0] l);
    start      = 1'b1;
    first_addr = f;
    last_addr  = l;
    step();
    start = 1'b0;
  endtask

  // Runs the sink; cyc 0 is the cycle right after the start edge.
  // Words are recorded in the cycle whose closing edge transfers them.
  task automatic collect(input int rmode, input int inj_cyc,
                         input int abort_after, input int maxc);
    logic  pend;
    word_t held;
    int    idle_cnt;
    wq.delete();
    n_done = 0;
    done_cyc = -1;
    last_xfer_cyc = -1;
    first_valid_cyc = -1;
    hold_errs = 0;
    n_err = 0;
    pend = 1'b0;
    idle_cnt = 0;
    held = '{'0, '0, 1'b0};
    for (int cyc = 0; cyc < maxc; cyc++) begin
      dif.dump_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
      if (cyc == inj_cyc) begin
        start = 1'b1;
        first_addr = 5'd2;
        last_addr = 5'd31;
      end else begin
        start = 1'b0;
      end
      if (pend && dif.dump_valid &&
          (dif.dump_data !== held.d ||
           dif.dump_addr !== held.a ||
           dif.dump_last !== held.l))
        hold_errs++;
      pend = 1'b0;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err) n_err++;
      if (dif.dump_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        held = '{dif.dump_addr, dif.dump_data, dif.dump_last};
        if (dif.dump_ready) begin
          wq.push_back(held);
          last_xfer_cyc = cyc;
        end else begin
          pend = 1'b1;
        end
      end
      if (!busy && cyc > 0) idle_cnt++;
      else idle_cnt = 0;
      step();
      if (abort_after > 0 && wq.size() == abort_after) break;
      if (idle_cnt >= 3) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    first_addr = '0;
    last_addr = '0;
    first2 = '0;
    last2 = '0;
    dif.dump_ready = 1'b0;
    dif2.dump_ready = 1'b1;
    step();
    step();
    vectors++;
    if ({busy, done, err} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_status got %b want 000",
               {busy, done, err});
    end
    vectors++;
    if ({dif.dump_valid, dif.dump_last} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_valid_last got %b want 00",
               {dif.dump_valid, dif.dump_last});
    end
    vectors++;
    if (dif.dump_data !== '0 || dif.dump_addr !== '0 ||
        rd_addr !== '0) begin
      miscompares++;
      $display("FAIL reset_regs data %h addr %h rd %h want 0",
               dif.dump_data, dif.dump_addr, rd_addr);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_full_dump();
    int bad;
    start_dump(5'd0, 5'd31);
    collect(0, -1, 0, 300);
    bad = 0;
    vectors++;
    if (wq.size() != 32) begin
      miscompares++;
      $display("FAIL full_count got %0d want 32", wq.size());
    end
    foreach (wq[i])
      if (wq[i].a !== AW'(i) || wq[i].d !== i * 32'h1111_1111 ||
          wq[i].l !== (i == 31))
        bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL full_words got %0d bad want 0", bad);
    end
    vectors++;
    if (first_valid_cyc != 1) begin
      miscompares++;
      $display("FAIL full_latency got %0d want 1", first_valid_cyc);
    end
    vectors++;
    if (n_done != 1 || done_cyc != 64) begin
      miscompares++;
      $display("FAIL full_done got %0d@%0d want 1@64",
               n_done, done_cyc);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    start_dump(5'd0, 5'd31);
    collect(1, -1, 0, 400);
    bad = 0;
    vectors++;
    if (wq.size() != 32) begin
      miscompares++;
      $display("FAIL bp_count got %0d want 32", wq.size());
    end
    foreach (wq[i])
      if (wq[i].a !== AW'(i) || wq[i].d !== i * 32'h1111_1111 ||
          wq[i].l !== (i == 31))
        bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL bp_words got %0d bad want 0", bad);
    end
    vectors++;
    if (hold_errs != 0) begin
      miscompares++;
      $display("FAIL bp_hold got %0d changes want 0", hold_errs);
    end
    vectors++;
    if (n_done != 1 || done_cyc != last_xfer_cyc + 1) begin
      miscompares++;
      $display("FAIL bp_done got %0d@%0d want 1@%0d",
               n_done, done_cyc, last_xfer_cyc + 1);
    end
  endtask

  task automatic test_single();
    bank[5] = 32'hDEAD_BEEF;
    start_dump(5'd5, 5'd5);
    collect(0, -1, 0, 50);
    vectors++;
    if (wq.size() != 1) begin
      miscompares++;
      $display("FAIL single_count got %0d want 1", wq.size());
    end else begin
      vectors++;
      if (wq[0].d !== 32'hDEAD_BEEF || wq[0].a !== 5'd5 ||
          wq[0].l !== 1'b1) begin
        miscompares++;
        $display("FAIL single_word got %h/%0d/%b want deadbeef/5/1",
                 wq[0].d, wq[0].a, wq[0].l);
      end
    end
    vectors++;
    if (n_done != 1 || done_cyc != 2) begin
      miscompares++;
      $display("FAIL single_done got %0d@%0d want 1@2",
               n_done, done_cyc);
    end
    bank[5] = 5 * 32'h1111_1111;
  endtask

  task automatic test_illegal();
    int seen;
    start = 1'b1;
    first_addr = 5'd9;
    last_addr = 5'd3;
    start2 = 1'b1;
    first2 = 6'd0;
    last2 = 6'd32;
    dif.dump_ready = 1'b1;
    step();
    start = 1'b0;
    start2 = 1'b0;
    vectors++;
    if ({err, busy, dif.dump_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL ill_order got %b want 100",
               {err, busy, dif.dump_valid});
    end
    vectors++;
    if ({err2, busy2, dif2.dump_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL ill_range got %b want 100",
               {err2, busy2, dif2.dump_valid});
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (err || busy || dif.dump_valid) seen++;
      if (err2 || busy2 || dif2.dump_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL ill_after got %0d events want 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int bad;
    start_dump(5'd0, 5'd31);
    collect(0, -1, 10, 300);
    vectors++;
    if (wq.size() != 10) begin
      miscompares++;
      $display("FAIL rst_pre got %0d words want 10", wq.size());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({busy, done, err, dif.dump_valid, dif.dump_last} !== 5'b0 ||
        dif.dump_data !== '0 || dif.dump_addr !== '0 ||
        rd_addr !== '0) begin
      miscompares++;
      $display("FAIL rst_mid got %b %h %h %h want 0",
               {busy, done, err, dif.dump_valid, dif.dump_last},
               dif.dump_data, dif.dump_addr, rd_addr);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || dif.dump_valid) seen++;
      step();
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_quiet got %0d events want 0", seen);
    end
    start_dump(5'd0, 5'd31);
    collect(0, -1, 0, 300);
    bad = 0;
    foreach (wq[i])
      if (wq[i].a !== AW'(i) || wq[i].d !== i * 32'h1111_1111)
        bad++;
    vectors++;
    if (wq.size() != 32 || bad != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL rst_redump got %0d words %0d bad %0d done want 32/0/1",
               wq.size(), bad, n_done);
    end
  endtask

  task automatic test_start_busy();
    int bad;
    start_dump(5'd0, 5'd31);
    collect(0, 5, 0, 300);
    bad = 0;
    foreach (wq[i])
      if (wq[i].a !== AW'(i) || wq[i].d !== i * 32'h1111_1111)
        bad++;
    vectors++;
    if (wq.size() != 32 || bad != 0) begin
      miscompares++;
      $display("FAIL busy_seq got %0d words %0d bad want 32/0",
               wq.size(), bad);
    end
    vectors++;
    if (n_err != 0 || n_done != 1) begin
      miscompares++;
      $display("FAIL busy_flags got err %0d done %0d want 0/1",
               n_err, n_done);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) bank[i] = i * 32'h1111_1111;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_single();
    test_illegal();
    test_reset_mid();
    test_start_busy();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
